// File: rtl/omsp_spm_pkg.sv
// Shared codes, FSM states and range helpers for the multi-slot Sancus protection table.
package omsp_spm_pkg;

    typedef enum logic {
        OP_ENABLE  = 1'b0,
        OP_DISABLE = 1'b1
    } spm_op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_INVALID = 2'd1,
        ST_OVERLAP = 2'd2,
        ST_FULL    = 2'd3
    } spm_status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT,
        S_RESP
    } spm_state_e;

    localparam int CAUSE_MEM  = 0;
    localparam int CAUSE_EXEC = 1;
    localparam int CAUSE_DMA  = 2;
    localparam int CAUSE_W    = 3;

    // Half-open ranges [a_s, a_e) and [b_s, b_e) share at least one address.
    function automatic logic overlap(input logic [31:0] a_s, input logic [31:0] a_e,
                                     input logic [31:0] b_s, input logic [31:0] b_e);
        return (a_s < b_e) && (a_e > b_s);
    endfunction

endpackage

// File: rtl/omsp_spm_slot.sv
// One protected-module descriptor: bound/id registers plus the per-slot range compares.
module omsp_spm_slot #(
    parameter int AW   = 16,
    parameter int ID_W = 16
) (
    input  logic            mclk,
    input  logic            puc_rst_n,
    input  logic            wr_i,
    input  logic            clr_i,
    input  logic [AW-1:0]   pub_s_i,
    input  logic [AW-1:0]   pub_e_i,
    input  logic [AW-1:0]   sec_s_i,
    input  logic [AW-1:0]   sec_e_i,
    input  logic [ID_W-1:0] id_i,
    input  logic [AW-1:0]   pc_i,
    input  logic [AW-1:0]   prev_pc_i,
    input  logic [AW-1:0]   addr_i,
    output logic            en_o,
    output logic [AW-1:0]   pub_s_o,
    output logic [AW-1:0]   pub_e_o,
    output logic [AW-1:0]   sec_s_o,
    output logic [AW-1:0]   sec_e_o,
    output logic [ID_W-1:0] id_o,
    output logic            pc_hit_o,
    output logic            pub_hit_o,
    output logic            sec_hit_o,
    output logic            exec_viol_o
);
    logic            en_q;
    logic [AW-1:0]   pub_s_q, pub_e_q, sec_s_q, sec_e_q;
    logic [ID_W-1:0] id_q;
    logic            prev_in_pub;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n || clr_i) begin
            en_q    <= 1'b0;
            pub_s_q <= '0;
            pub_e_q <= '0;
            sec_s_q <= '0;
            sec_e_q <= '0;
            id_q    <= '0;
        end else if (wr_i) begin
            en_q    <= 1'b1;
            pub_s_q <= pub_s_i;
            pub_e_q <= pub_e_i;
            sec_s_q <= sec_s_i;
            sec_e_q <= sec_e_i;
            id_q    <= id_i;
        end
    end

    assign en_o    = en_q;
    assign pub_s_o = pub_s_q;
    assign pub_e_o = pub_e_q;
    assign sec_s_o = sec_s_q;
    assign sec_e_o = sec_e_q;
    assign id_o    = id_q;

    assign prev_in_pub = (prev_pc_i >= pub_s_q) && (prev_pc_i < pub_e_q);
    assign pc_hit_o    = en_q && (pc_i >= pub_s_q) && (pc_i < pub_e_q);
    assign pub_hit_o   = en_q && (addr_i >= pub_s_q) && (addr_i < pub_e_q);
    assign sec_hit_o   = en_q && (addr_i >= sec_s_q) && (addr_i < sec_e_q);
    // Entering the public section anywhere but its first word is an illegal jump.
    assign exec_viol_o = pc_hit_o && !prev_in_pub && (pc_i != pub_s_q);

endmodule

// File: rtl/omsp_spm_table.sv
// N_SLOTS-entry SM descriptor table with parallel access checks and a sequential create scan.
// Define OMSP_SPM_SECRET_OVERLAP_EN to also reject secret-range overlaps during the scan.
module omsp_spm_table
    import omsp_spm_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int AW      = 16,
    parameter int ID_W    = 16,
    localparam int SW     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic            mclk,
    input  logic            puc_rst_n,
    input  logic [AW-1:0]   pc,
    input  logic [AW-1:0]   prev_pc,
    input  logic [AW-1:0]   address,
    input  logic            mb_en,
    input  logic [1:0]      mb_wr,
    input  logic            dma_en,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [AW-1:0]   cmd_pub_start,
    input  logic [AW-1:0]   cmd_pub_end,
    input  logic [AW-1:0]   cmd_sec_start,
    input  logic [AW-1:0]   cmd_sec_end,
    input  logic [ID_W-1:0] cmd_id,
    output logic            rsp_valid,
    output logic [1:0]      rsp_status,
    output logic [SW-1:0]   rsp_slot,
    output logic            executing,
    output logic [ID_W-1:0] exec_id,
    output logic            violation,
    output logic [2:0]      last_cause
);
    localparam logic [SW-1:0] LAST = SW'(N_SLOTS - 1);

    logic [N_SLOTS-1:0]           en_a, wr_a, clr_a, pc_hit_a, pub_hit_a, sec_hit_a, xv_a;
    logic [N_SLOTS-1:0][AW-1:0]   pub_s_a, pub_e_a, sec_s_a, sec_e_a;
    logic [N_SLOTS-1:0][ID_W-1:0] id_a;

    spm_state_e           state_q;
    logic [SW-1:0]        idx_q, free_slot_q, rsp_slot_q, dis_slot;
    logic                 free_found_q;
    logic [AW-1:0]        c_pub_s_q, c_pub_e_q, c_sec_s_q, c_sec_e_q;
    logic [ID_W-1:0]      c_id_q;
    logic [1:0]           rsp_status_q;
    logic [CAUSE_W-1:0]   cause, last_cause_q;
    logic                 accept, dis_acc, scan_ovl;

    assign accept  = cmd_valid && (state_q == S_IDLE);
    assign dis_acc = accept && (cmd_op == OP_DISABLE);

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign wr_a[k]  = (state_q == S_COMMIT) && (free_slot_q == SW'(k));
        assign clr_a[k] = dis_acc && pc_hit_a[k];
        omsp_spm_slot #(.AW(AW), .ID_W(ID_W)) u_slot (
            .mclk(mclk), .puc_rst_n(puc_rst_n), .wr_i(wr_a[k]), .clr_i(clr_a[k]),
            .pub_s_i(c_pub_s_q), .pub_e_i(c_pub_e_q), .sec_s_i(c_sec_s_q), .sec_e_i(c_sec_e_q),
            .id_i(c_id_q), .pc_i(pc), .prev_pc_i(prev_pc), .addr_i(address),
            .en_o(en_a[k]), .pub_s_o(pub_s_a[k]), .pub_e_o(pub_e_a[k]),
            .sec_s_o(sec_s_a[k]), .sec_e_o(sec_e_a[k]), .id_o(id_a[k]),
            .pc_hit_o(pc_hit_a[k]), .pub_hit_o(pub_hit_a[k]), .sec_hit_o(sec_hit_a[k]),
            .exec_viol_o(xv_a[k])
        );
    end

    always_comb begin
        scan_ovl = en_a[idx_q] && overlap(32'(c_pub_s_q), 32'(c_pub_e_q),
                                          32'(pub_s_a[idx_q]), 32'(pub_e_a[idx_q]));
`ifdef OMSP_SPM_SECRET_OVERLAP_EN
        scan_ovl = scan_ovl || (en_a[idx_q] && (
            overlap(32'(c_sec_s_q), 32'(c_sec_e_q), 32'(sec_s_a[idx_q]), 32'(sec_e_a[idx_q])) ||
            overlap(32'(c_pub_s_q), 32'(c_pub_e_q), 32'(sec_s_a[idx_q]), 32'(sec_e_a[idx_q])) ||
            overlap(32'(c_sec_s_q), 32'(c_sec_e_q), 32'(pub_s_a[idx_q]), 32'(pub_e_a[idx_q]))));
`endif
    end

`ifndef OMSP_SPM_SECRET_OVERLAP_EN
    logic unused_sec_bounds;
    assign unused_sec_bounds = ^{sec_s_a, sec_e_a};
`endif

    assign executing = |pc_hit_a;
    assign violation = |cause;

    // Public ranges never overlap, so at most one slot claims the pc and OR-reducing ids is exact.
    always_comb begin
        cause    = '0;
        exec_id  = '0;
        dis_slot = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (pc_hit_a[k]) begin
                exec_id  = exec_id | id_a[k];
                dis_slot = SW'(k);
            end
            if (mb_en && !pc_hit_a[k]) begin
                if (sec_hit_a[k]) cause[CAUSE_MEM] = 1'b1;
                if (pub_hit_a[k] && ((mb_wr != 2'b00) || executing)) cause[CAUSE_MEM] = 1'b1;
            end
            if (mb_en && dma_en && (pub_hit_a[k] || sec_hit_a[k])) cause[CAUSE_DMA] = 1'b1;
            if (xv_a[k]) cause[CAUSE_EXEC] = 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) last_cause_q <= '0;
        else if (violation) last_cause_q <= cause;
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            free_slot_q  <= '0;
            free_found_q <= 1'b0;
            c_pub_s_q    <= '0;
            c_pub_e_q    <= '0;
            c_sec_s_q    <= '0;
            c_sec_e_q    <= '0;
            c_id_q       <= '0;
            rsp_status_q <= ST_OK;
            rsp_slot_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    rsp_slot_q <= '0;
                    if (cmd_op == OP_DISABLE) begin
                        state_q      <= S_RESP;
                        rsp_status_q <= executing ? ST_OK : ST_INVALID;
                        rsp_slot_q   <= executing ? dis_slot : '0;
                    end else begin
                        c_pub_s_q    <= cmd_pub_start;
                        c_pub_e_q    <= cmd_pub_end;
                        c_sec_s_q    <= cmd_sec_start;
                        c_sec_e_q    <= cmd_sec_end;
                        c_id_q       <= cmd_id;
                        idx_q        <= '0;
                        free_found_q <= 1'b0;
                        if (!(cmd_pub_start < cmd_pub_end) || !(cmd_sec_start <= cmd_sec_end)) begin
                            state_q      <= S_RESP;
                            rsp_status_q <= ST_INVALID;
                        end else begin
                            state_q <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_ovl) begin
                        state_q      <= S_RESP;
                        rsp_status_q <= ST_OVERLAP;
                    end else begin
                        if (!en_a[idx_q] && !free_found_q) begin
                            free_found_q <= 1'b1;
                            free_slot_q  <= idx_q;
                        end
                        if (idx_q == LAST) begin
                            if (!free_found_q && en_a[idx_q]) begin
                                state_q      <= S_RESP;
                                rsp_status_q <= ST_FULL;
                            end else begin
                                state_q <= S_COMMIT;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q      <= S_RESP;
                    rsp_status_q <= ST_OK;
                    rsp_slot_q   <= free_slot_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = rsp_status_q;
    assign rsp_slot   = rsp_slot_q;
    assign last_cause = last_cause_q;

endmodule

// File: tb/tb_omsp_spm_table.sv
// Bench for omsp_spm_table: command scoreboard with latency checks plus a table of access vectors.
module tb_omsp_spm_table;
    logic        mclk, puc_rst_n;
    logic [15:0] pc, prev_pc, address;
    logic        mb_en, dma_en;
    logic [1:0]  mb_wr;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [15:0] cmd_pub_start, cmd_pub_end, cmd_sec_start, cmd_sec_end, cmd_id;
    logic        rsp_valid;
    logic [1:0]  rsp_status, rsp_slot;
    logic        executing, violation;
    logic [15:0] exec_id;
    logic [2:0]  last_cause;

    omsp_spm_table #(.N_SLOTS(4), .AW(16), .ID_W(16)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n), .pc(pc), .prev_pc(prev_pc), .address(address),
        .mb_en(mb_en), .mb_wr(mb_wr), .dma_en(dma_en), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pub_start(cmd_pub_start),
        .cmd_pub_end(cmd_pub_end), .cmd_sec_start(cmd_sec_start), .cmd_sec_end(cmd_sec_end),
        .cmd_id(cmd_id), .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_slot(rsp_slot),
        .executing(executing), .exec_id(exec_id), .violation(violation), .last_cause(last_cause)
    );

    typedef struct {
        logic [1:0] status;
        int         slot;
        int         acc;
        int         lat;
    } exp_rsp_t;

    typedef struct {
        logic [15:0] pc, prev, addr;
        logic        en;
        logic [1:0]  wr;
        logic        dma;
        logic [2:0]  cause;
        logic        exec;
        logic [15:0] id;
    } vec_t;

    exp_rsp_t sb[$];
    vec_t     vt[18];
    int       checks = 0, errors = 0, cyc = 0;
    logic [2:0] exp_last;

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge mclk) begin : mon
        exp_rsp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 status=%0d, expected no response", rsp_status);
            end else begin
                e = sb.pop_front();
                chk("rsp_status", 32'(rsp_status), 32'(e.status));
                chk("rsp_slot", 32'(rsp_slot), e.slot);
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic idle_inputs();
        pc = 16'h1000; prev_pc = 16'h1000; address = 16'h0000;
        mb_en = 1'b0; mb_wr = 2'b00; dma_en = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [15:0] ps, input logic [15:0] pe,
                         input logic [15:0] ss, input logic [15:0] se, input logic [15:0] id,
                         input logic [1:0] st, input int slot, input int lat);
        int n;
        @(negedge mclk);
        cmd_op = op; cmd_pub_start = ps; cmd_pub_end = pe;
        cmd_sec_start = ss; cmd_sec_end = se; cmd_id = id; cmd_valid = 1'b1;
        sb.push_back('{st, slot, cyc, lat});
        @(negedge mclk);
        cmd_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge mclk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no response in 40 cycles, expected status %0d", st);
            sb.delete();
        end
        @(negedge mclk);
    endtask

    task automatic apply(input int i);
        @(negedge mclk);
        pc = vt[i].pc; prev_pc = vt[i].prev; address = vt[i].addr;
        mb_en = vt[i].en; mb_wr = vt[i].wr; dma_en = vt[i].dma;
        #1;
        chk($sformatf("v%0d_violation", i), 32'(violation), 32'(|vt[i].cause));
        chk($sformatf("v%0d_executing", i), 32'(executing), 32'(vt[i].exec));
        chk($sformatf("v%0d_exec_id", i), 32'(exec_id), 32'(vt[i].id));
        if (vt[i].cause != 3'b000) exp_last = vt[i].cause;
        @(posedge mclk);
        #1;
        chk($sformatf("v%0d_last_cause", i), 32'(last_cause), 32'(exp_last));
    endtask

    initial begin
        // pc, prev_pc, address, mb_en, mb_wr, dma_en, cause, executing, exec_id
        vt[0]  = '{16'h1000, 16'h1000, 16'h0310, 1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 16'd0};
        vt[1]  = '{16'h8010, 16'h8000, 16'h0310, 1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 16'd5};
        vt[2]  = '{16'h8004, 16'h1000, 16'h0000, 1'b0, 2'b00, 1'b0, 3'b010, 1'b1, 16'd5};
        vt[3]  = '{16'h8000, 16'h1000, 16'h0000, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 16'd5};
        vt[4]  = '{16'h8100, 16'h1000, 16'h0000, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 16'd0};
        vt[5]  = '{16'h1000, 16'h1000, 16'h8050, 1'b1, 2'b10, 1'b0, 3'b001, 1'b0, 16'd0};
        vt[6]  = '{16'h1000, 16'h1000, 16'h8050, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 16'd0};
        vt[7]  = '{16'h1000, 16'h1000, 16'h0320, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 16'd0};
        vt[8]  = '{16'h1000, 16'h1000, 16'h02FF, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 16'd0};
        vt[9]  = '{16'h1000, 16'h1000, 16'h0300, 1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 16'd0};
        vt[10] = '{16'h1000, 16'h1000, 16'h8050, 1'b1, 2'b00, 1'b1, 3'b100, 1'b0, 16'd0};
        vt[11] = '{16'h8010, 16'h8000, 16'h0310, 1'b1, 2'b00, 1'b1, 3'b100, 1'b1, 16'd5};
        vt[12] = '{16'h1000, 16'h1000, 16'h0310, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 16'd0};
        // four slots populated
        vt[13] = '{16'hA010, 16'hA000, 16'h8050, 1'b1, 2'b00, 1'b0, 3'b001, 1'b1, 16'd7};
        vt[14] = '{16'h8010, 16'h8000, 16'h8050, 1'b1, 2'b01, 1'b0, 3'b000, 1'b1, 16'd5};
        vt[15] = '{16'hB000, 16'h80FE, 16'h0000, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 16'd8};
        vt[16] = '{16'hC010, 16'h8010, 16'h0000, 1'b0, 2'b00, 1'b0, 3'b010, 1'b1, 16'd9};
        // after slot 0 is disabled
        vt[17] = '{16'h1000, 16'h1000, 16'h0310, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 16'd0};

        puc_rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_id = '0;
        cmd_pub_start = '0; cmd_pub_end = '0; cmd_sec_start = '0; cmd_sec_end = '0;
        idle_inputs();
        exp_last = 3'b000;
        #1 puc_rst_n = 1'b0;
        repeat (3) @(negedge mclk);
        puc_rst_n = 1'b1;
        @(negedge mclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_status", 32'(rsp_status), 0);
        chk("rst_rsp_slot", 32'(rsp_slot), 0);
        chk("rst_executing", 32'(executing), 0);
        chk("rst_exec_id", 32'(exec_id), 0);
        chk("rst_violation", 32'(violation), 0);
        chk("rst_last_cause", 32'(last_cause), 0);

        issue(1'b0, 16'h8000, 16'h8100, 16'h0300, 16'h0320, 16'd5, 2'd0, 0, 6);
        issue(1'b0, 16'h80F0, 16'h8200, 16'h0800, 16'h0810, 16'd6, 2'd2, 0, 2);
        issue(1'b0, 16'h9000, 16'h9000, 16'h0330, 16'h0340, 16'd6, 2'd1, 0, 1);
        issue(1'b0, 16'h9000, 16'h9100, 16'h0330, 16'h0320, 16'd6, 2'd1, 0, 1);
        for (int i = 0; i <= 12; i++) apply(i);

        idle_inputs();
        issue(1'b0, 16'hA000, 16'hA100, 16'h0400, 16'h0410, 16'd7, 2'd0, 1, 6);
        issue(1'b0, 16'hB000, 16'hB100, 16'h0500, 16'h0510, 16'd8, 2'd0, 2, 6);
        issue(1'b0, 16'hC000, 16'hC100, 16'h0600, 16'h0610, 16'd9, 2'd0, 3, 6);
        issue(1'b0, 16'hB0FF, 16'hB200, 16'h0800, 16'h0810, 16'd6, 2'd2, 0, 4);
        issue(1'b0, 16'h8100, 16'h8200, 16'h0700, 16'h0710, 16'd6, 2'd3, 0, 5);
        for (int i = 13; i <= 16; i++) apply(i);

        idle_inputs();
        pc = 16'h8010; prev_pc = 16'h8000;
        issue(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0, 2'd0, 0, 1);
        idle_inputs();
        issue(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd0, 2'd1, 0, 1);
        apply(17);
        idle_inputs();
        issue(1'b0, 16'hE000, 16'hE100, 16'h0900, 16'h0910, 16'd10, 2'd0, 0, 6);

        // reset lands while the scan is two slots in: no response may follow
        @(negedge mclk);
        cmd_op = 1'b0; cmd_pub_start = 16'hF000; cmd_pub_end = 16'hF100;
        cmd_sec_start = 16'h0A00; cmd_sec_end = 16'h0A10; cmd_id = 16'd11; cmd_valid = 1'b1;
        @(negedge mclk);
        cmd_valid = 1'b0;
        @(negedge mclk);
        puc_rst_n = 1'b0;
        exp_last = 3'b000;
        #1;
        chk("scan_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("scan_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("scan_rst_last_cause", 32'(last_cause), 32'(exp_last));
        @(negedge mclk);
        puc_rst_n = 1'b1;
        repeat (10) @(negedge mclk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        pc = 16'hC010; prev_pc = 16'hC000;
        #1;
        chk("post_rst_executing", 32'(executing), 0);
        chk("post_rst_exec_id", 32'(exec_id), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/omsp_spm_table.md
# omsp_spm_table

Multi-slot successor to the single-module Sancus protection unit: holds `N_SLOTS` protected-module (SM) descriptors in one table and checks every memory access and PC transition against all of them in parallel. Placed beside the openMSP430 execution unit on the memory-backbone side. SM creation runs as a sequential overlap scan over the table, driven by a valid/ready command port with a one-cycle response pulse.

## Interface
Parameters:
- `N_SLOTS`, 4, number of SM descriptors (2..16)
- `AW`, 16, address/PC width
- `ID_W`, 16, SM identifier width

Ports:
- `mclk`  in  1  system clock
- `puc_rst_n`  in  1  asynchronous, active-low reset
- `pc`, `prev_pc`  in  AW  current and previous-cycle program counter
- `address`  in  AW  memory-backbone address
- `mb_en`  in  1  memory access strobe
- `mb_wr`  in  2  byte write enables
- `dma_en`  in  1  access originates from DMA
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_op`  in  1  0 = ENABLE, 1 = DISABLE
- `cmd_pub_start`, `cmd_pub_end`, `cmd_sec_start`, `cmd_sec_end`  in  AW  new SM layout
- `cmd_id`  in  ID_W  id for new SM
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_status`  out  2  0 OK, 1 INVALID, 2 OVERLAP, 3 FULL
- `rsp_slot`  out  log2(N_SLOTS)  slot written or disabled
- `executing`  out  1  `pc` inside the public range of some enabled slot
- `exec_id`  out  ID_W  id of that slot, 0 if none
- `violation`  out  1  combinational, same cycle as offending access
- `last_cause`  out  3  sticky cause of the most recent violation: bit0 mem, bit1 exec, bit2 dma

## Operation
- Slot k is active iff `en[k]`; ranges are half-open `[start, end)`.
- Mem violation, any enabled k: access to secret k while not executing in public k; or access to public k with `mb_wr != 0` while not executing in k, or read of public k while executing in another slot.
- Exec violation: `pc` in public k, `prev_pc` not in public k, `pc != pub_start[k]`.
- DMA violation: `dma_en & mb_en` hitting any enabled range.
- FSM states: IDLE, SCAN, COMMIT, RESP.
- ENABLE accept (`cmd_valid & cmd_ready`) latches command. If `!(pub_start < pub_end) | !(sec_start <= sec_end)` go to RESP with INVALID; else go to SCAN, index 0.
- SCAN: one slot per cycle. Enabled slot with public/public overlap (`a_s < b_e & a_e > b_s`) goes to RESP with OVERLAP immediately. Lowest-index free slot is recorded. After index N_SLOTS-1: no free slot goes to RESP with FULL, else to COMMIT.
- COMMIT writes the four bounds, id and `en`, then goes to RESP with OK and `rsp_slot`.
- DISABLE: the slot whose public range contains `pc` is cleared (bounds 0, id 0, `en` 0) on the accept edge, then RESP OK. No such slot gives RESP INVALID.
- RESP: `rsp_valid = 1` for one cycle, then IDLE.
- `last_cause` updates on every violation cycle. Unchanged otherwise.

## Timing
- Reset: all slots cleared, FSM to IDLE. Outputs: `cmd_ready = 1`, `rsp_valid = 0`, `rsp_status = 0`, `rsp_slot = 0`, `executing = 0`, `exec_id = 0`, `violation = 0`, `last_cause = 0`. Reset mid-scan aborts the scan with no response.
- Latency from accept edge to `rsp_valid`:
  - ENABLE OK: N_SLOTS+2 cycles
  - OVERLAP: i+2 cycles, i = offending index
  - FULL: N_SLOTS+1 cycles
  - INVALID or DISABLE: 1 cycle
- Access checks always use the table as currently registered. A committed slot protects from the cycle after COMMIT. A disabled slot stops protecting in the cycle after accept.
- Commands are not queued. `cmd_valid` outside IDLE is ignored.
- `executing`, `exec_id` and `violation` are combinational from `pc`, `prev_pc` and `address`.
- With overlapping public ranges impossible by construction, at most one slot matches `pc`.

## Configuration
- `OMSP_SPM_SECRET_OVERLAP_EN` defined: each SCAN step additionally rejects secret/secret, new-public/old-secret and new-secret/old-public overlaps, giving OVERLAP.
- Undefined: SCAN checks public/public only. Secret ranges may overlap other SMs.

## Structure
- Package `omsp_spm_pkg` holds:
  - op codes, status codes and the FSM state enum
  - cause bit positions
  - the `overlap` function
- Sub-module `omsp_spm_slot` (one descriptor: registers, write/clear, range-hit and exec compares) is instantiated N_SLOTS times.
- The top-level holds the FSM, the scan index, hit reduction and violation logic.

## Test plan
- ENABLE pub 0x8000–0x8100, sec 0x0300–0x0320, id 5 with N_SLOTS=4 -> OK slot 0, `rsp_valid` 6 cycles after accept.
- Then ENABLE pub 0x80F0–0x8200 -> OVERLAP 2 cycles after accept. Table unchanged.
- Four valid disjoint ENABLEs, then a fifth -> FULL 5 cycles after accept.
- `pc` = 0x1000 reading 0x0310 -> `violation = 1`, `last_cause = 001`. Same read with `pc` = 0x8010 -> no violation, `exec_id = 5`.
- `prev_pc` = 0x1000, `pc` = 0x8004 -> exec violation. `pc` = 0x8000 -> none.
- DISABLE with `pc` = 0x8010 -> OK slot 0, then a 0x0310 read from 0x1000 is allowed. Reset during SCAN -> `cmd_ready = 1`, no `rsp_valid`.
